// File: rtl/xy_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : xy_port_arbiter
// Description : Shares one router output port between the left, bottom and
//               local PE requesters. Round-robin grant with starvation
//               escalation feeding a single-entry ready/valid output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module xy_port_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int X_SIZE      = 2,
  parameter int Y_SIZE      = 2,
  parameter int TOTAL_WIDTH = 2*X_SIZE + 2*Y_SIZE + DATA_WIDTH,
  parameter int MAX_WAIT    = 7
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_valid_l,
  input  logic                   i_valid_b,
  input  logic                   i_valid_pe,
  input  logic [TOTAL_WIDTH-1:0] i_data_l,
  input  logic [TOTAL_WIDTH-1:0] i_data_b,
  input  logic [TOTAL_WIDTH-1:0] i_data_pe,
  output logic                   o_ready_l,
  output logic                   o_ready_b,
  output logic                   o_ready_pe,
  output logic                   o_valid,
  output logic [TOTAL_WIDTH-1:0] o_data,
  input  logic                   i_ready,
  output logic [1:0]             o_grant
);

  // Wait counters are 4 bits wide, enough for any MAX_WAIT in 1..15.
  localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

  logic [2:0]             w_valid;
  logic                   w_load_en;
  logic                   w_found;
  logic [1:0]             w_winner;
  logic                   w_accept;
  logic [1:0]             w_ord [3];
  logic [TOTAL_WIDTH-1:0] w_win_data;

  logic                   r_valid;
  logic [TOTAL_WIDTH-1:0] r_data;
  logic [1:0]             r_grant;
  logic [1:0]             r_rr;
  logic [3:0]             r_wait [3];

  assign w_valid   = {i_valid_pe, i_valid_b, i_valid_l};
  // The stage can take a new flit when empty or when its flit leaves now.
  assign w_load_en = ~r_valid | i_ready;

  // Search order starting at the round-robin pointer, wrapping 0->1->2->0.
  always_comb begin
    w_ord[0] = 2'd0;
    w_ord[1] = 2'd1;
    w_ord[2] = 2'd2;
    case (r_rr)
      2'd1: begin
        w_ord[0] = 2'd1;
        w_ord[1] = 2'd2;
        w_ord[2] = 2'd0;
      end
      2'd2: begin
        w_ord[0] = 2'd2;
        w_ord[1] = 2'd0;
        w_ord[2] = 2'd1;
      end
      default: ;
    endcase
  end

  // Winner selection: starved requester (lowest index) first, else round-robin.
  always_comb begin
    w_winner = 2'd0;
    w_found  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!w_found && w_valid[i] && (r_wait[i] == c_max_wait)) begin
        w_winner = 2'(i);
        w_found  = 1'b1;
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (!w_found && w_valid[w_ord[k]]) begin
        w_winner = w_ord[k];
        w_found  = 1'b1;
      end
    end
  end

  // Payload of the selected requester.
  always_comb begin
    case (w_winner)
      2'd1:    w_win_data = i_data_b;
      2'd2:    w_win_data = i_data_pe;
      default: w_win_data = i_data_l;
    endcase
  end

  // Gating with rstn keeps ready pulses silent while reset is held.
  assign w_accept   = rstn & w_load_en & w_found;
  assign o_ready_l  = w_accept & (w_winner == 2'd0) & i_valid_l;
  assign o_ready_b  = w_accept & (w_winner == 2'd1) & i_valid_b;
  assign o_ready_pe = w_accept & (w_winner == 2'd2) & i_valid_pe;

  // Output stage, grant record and round-robin pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_grant <= 2'd3;
      r_rr    <= 2'd0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= w_win_data;
      r_grant <= w_winner;
      r_rr    <= (w_winner == 2'd2) ? 2'd0 : w_winner + 2'd1;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Per-requester denial counters; frozen during output stalls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 3; i++) r_wait[i] <= 4'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!w_valid[i]) begin
          r_wait[i] <= 4'd0;
        end else if (w_load_en) begin
          if (w_accept && (w_winner == 2'(i))) begin
            r_wait[i] <= 4'd0;
          end else if (r_wait[i] != c_max_wait) begin
            r_wait[i] <= r_wait[i] + 4'd1;
          end
        end
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_grant = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_xy_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_xy_port_arbiter
// Description : Directed self-checking bench for xy_port_arbiter. One
//               instance at default MAX_WAIT, a second at MAX_WAIT=1 so the
//               starvation override can beat the round-robin choice.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xy_port_arbiter;

  localparam int c_tw = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rstn;
  // instance 1 (MAX_WAIT default)
  logic            vl, vb, vpe, rl, rb, rpe, ov, ir;
  logic [c_tw-1:0] dl, db, dpe, od;
  logic [1:0]      og;
  // instance 2 (MAX_WAIT = 1)
  logic            vl2, vb2, vpe2, rl2, rb2, rpe2, ov2, ir2;
  logic [c_tw-1:0] dl2, db2, dpe2, od2;
  logic [1:0]      og2;

  int n_checks = 0;
  int n_errors = 0;

  xy_port_arbiter u_dut (
    .clk(clk), .rstn(rstn),
    .i_valid_l(vl), .i_valid_b(vb), .i_valid_pe(vpe),
    .i_data_l(dl), .i_data_b(db), .i_data_pe(dpe),
    .o_ready_l(rl), .o_ready_b(rb), .o_ready_pe(rpe),
    .o_valid(ov), .o_data(od), .i_ready(ir), .o_grant(og)
  );

  xy_port_arbiter #(.MAX_WAIT(1)) u_dut_sw (
    .clk(clk), .rstn(rstn),
    .i_valid_l(vl2), .i_valid_b(vb2), .i_valid_pe(vpe2),
    .i_data_l(dl2), .i_data_b(db2), .i_data_pe(dpe2),
    .o_ready_l(rl2), .o_ready_b(rb2), .o_ready_pe(rpe2),
    .o_valid(ov2), .o_data(od2), .i_ready(ir2), .o_grant(og2)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int              cnt [3];
    logic [2:0]      exp_vec;
    logic [c_tw-1:0] exp_data;
    logic [c_tw-1:0] saved;

    rstn = 1'b0;
    vl = 0; vb = 0; vpe = 0; dl = '0; db = '0; dpe = '0; ir = 0;
    vl2 = 0; vb2 = 0; vpe2 = 0; dl2 = '0; db2 = '0; dpe2 = '0; ir2 = 0;

    // Reset state, with requests present: no readies while in reset.
    tick;
    vl = 1; vb = 1; vpe = 1; ir = 1;
    #1;
    check_val("rst_valid", ov, 0);
    check_val("rst_data", od, 0);
    check_val("rst_grant", og, 3);
    check_val("rst_ready", {rpe, rb, rl}, 3'b000);
    tick;
    vl = 0; vb = 0; vpe = 0;
    rstn = 1'b1;

    // Single bottom request.
    vb = 1; db = 16'h2A31; ir = 1;
    #1;
    check_val("single_ready", {rpe, rb, rl}, 3'b010);
    tick;
    vb = 0;
    check_val("single_valid", ov, 1);
    check_val("single_data", od, 16'h2A31);
    check_val("single_grant", og, 1);

    // Fairness: pointer back to left via reset pulse, then all valid.
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
    vl = 1; vb = 1; vpe = 1; ir = 1;
    dl = 16'h1000; db = 16'h2000; dpe = 16'h3000;
    for (int i = 0; i < 12; i++) begin
      #1;
      exp_vec = 3'b001 << (i % 3);
      check_val("fair_ready", {rpe, rb, rl}, exp_vec);
      exp_data = (i % 3 == 0) ? dl : ((i % 3 == 1) ? db : dpe);
      if (rl)  cnt[0]++;
      if (rb)  cnt[1]++;
      if (rpe) cnt[2]++;
      tick;
      check_val("fair_data", od, exp_data);
      check_val("fair_grant", og, i % 3);
      if (i % 3 == 0) dl  = dl + 1;
      if (i % 3 == 1) db  = db + 1;
      if (i % 3 == 2) dpe = dpe + 1;
    end
    check_val("fair_cnt_l", cnt[0], 4);
    check_val("fair_cnt_b", cnt[1], 4);
    check_val("fair_cnt_pe", cnt[2], 4);

    // Backpressure: stage full, downstream stalled for 5 cycles.
    ir = 0;
    saved = od;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_val("stall_ready", {rpe, rb, rl}, 3'b000);
      tick;
      check_val("stall_data", od, saved);
      check_val("stall_valid", ov, 1);
    end
    ir = 1;
    #1;
    check_val("stall_release", {rpe, rb, rl}, 3'b001);
    tick;
    check_val("stall_rel_data", od, 16'h1004);
    vl = 0; vb = 0; vpe = 0;

    // Throughput: left alone for 10 cycles.
    vl = 1; ir = 1;
    for (int i = 0; i < 10; i++) begin
      dl = 16'h4400 + 16'(i);
      #1;
      check_val("thru_ready", rl, 1);
      tick;
      check_val("thru_valid", ov, 1);
      check_val("thru_data", od, 16'h4400 + 16'(i));
    end
    vl = 0;
    #1;
    check_val("drain_ready", {rpe, rb, rl}, 3'b000);
    tick;
    check_val("drain_valid", ov, 0);
    check_val("drain_hold", od, 16'h4409);

    // Async reset while stalled; pointer left at PE beforehand.
    vb = 1; db = 16'h5B5B; ir = 1;
    tick;
    vb = 0; ir = 0;
    check_val("pre_rst_valid", ov, 1);
    check_val("pre_rst_grant", og, 1);
    #2;
    rstn = 1'b0;
    vl = 1; vb = 1; vpe = 1;
    #1;
    check_val("arst_valid", ov, 0);
    check_val("arst_data", od, 0);
    check_val("arst_grant", og, 3);
    check_val("arst_ready", {rpe, rb, rl}, 3'b000);
    #1;
    rstn = 1'b1;
    ir = 1;
    #1;
    check_val("post_rst_ready", {rpe, rb, rl}, 3'b001);
    tick;
    check_val("post_rst_grant", og, 0);
    vl = 0; vb = 0; vpe = 0;

    // Second instance: stall must not count as starvation.
    vl2 = 1; dl2 = 16'hA001; ir2 = 1;
    #1;
    check_val("sw_first", {rpe2, rb2, rl2}, 3'b001);
    tick;
    check_val("sw_first_valid", ov2, 1);
    ir2 = 0; vpe2 = 1; dpe2 = 16'hA0E1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("sw_stall_ready", {rpe2, rb2, rl2}, 3'b000);
      tick;
    end
    ir2 = 1;
    #1;
    check_val("sw_no_starve", {rpe2, rb2, rl2}, 3'b100);
    tick;
    check_val("sw_pe_data", od2, 16'hA0E1);
    // L (count 1) and PE valid: left granted, PE denied once.
    #1;
    check_val("sw_left", {rpe2, rb2, rl2}, 3'b001);
    tick;
    // Pointer at bottom, but PE reached MAX_WAIT: override.
    vl2 = 0; vb2 = 1; db2 = 16'hB0B0;
    #1;
    check_val("sw_override", {rpe2, rb2, rl2}, 3'b100);
    tick;
    check_val("sw_override_grant", og2, 2);
    // PE counter cleared by its grant: plain round-robin picks left.
    vl2 = 1; vb2 = 0;
    #1;
    check_val("sw_cleared", {rpe2, rb2, rl2}, 3'b001);
    tick;
    vl2 = 0; vpe2 = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
